// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage around a combinational ALU: buffers tagged commands in a
// FIFO, presents the head to the ALU and captures results into a response slot.
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_opcode,
  input  logic [DATA_W-1:0]            cmd_a,
  input  logic [DATA_W-1:0]            cmd_b,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic [1:0]                   alu_opcode,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  input  logic [DATA_W-1:0]            alu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_result,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic                         rsp_zero,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [1:0]        mem_op  [DEPTH];
  logic [DATA_W-1:0] mem_a   [DEPTH];
  logic [DATA_W-1:0] mem_b   [DEPTH];
  logic [TAG_W-1:0]  mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;
  logic             slot_free;

  // cmd_ready depends on occupancy only, so no combinational path from rsp_ready.
  assign empty     = (fifo_count == '0);
  assign cmd_ready = (fifo_count < CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign slot_free = !rsp_valid || rsp_ready;
  assign pop       = !empty && slot_free;

  always_comb begin
    alu_opcode = '0;
    alu_a      = '0;
    alu_b      = '0;
    if (!empty) begin
      alu_opcode = mem_op[rd_ptr];
      alu_a      = mem_a[rd_ptr];
      alu_b      = mem_b[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_op[wr_ptr]  <= cmd_opcode;
      mem_a[wr_ptr]   <= cmd_a;
      mem_b[wr_ptr]   <= cmd_b;
      mem_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_zero   <= 1'b0;
    end else if (flush) begin
      // Captured payload is deliberately kept; only the valid state is dropped.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop && !push)
        fifo_count <= fifo_count - 1'b1;
      if (pop) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_tag    <= mem_tag[rd_ptr];
        rsp_zero   <= (alu_result == '0);
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_count == CNT_W'(DEPTH)));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready && !flush) |=>
      (rsp_valid && $stable(rsp_result) && $stable(rsp_tag) && $stable(rsp_zero)));

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus random
// traffic checked every cycle against a queue-based transaction model.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_tag;
  logic [1:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_tag;
  logic       rsp_zero;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] tag;
  } cmd_t;

  cmd_t       q[$];
  logic       m_rv   = 1'b0;
  logic [7:0] m_res  = '0;
  logic [3:0] m_tag  = '0;
  logic       m_zero = 1'b0;

  function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // External combinational ALU the sequencer wraps.
  assign alu_result = alu_ref(alu_opcode, alu_a, alu_b);

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(8), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_zero(rsp_zero), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("cmd_ready",  32'(cmd_ready),  32'(q.size() < DEPTH));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    chk("rsp_valid",  32'(rsp_valid),  32'(m_rv));
    chk("rsp_result", 32'(rsp_result), 32'(m_res));
    chk("rsp_tag",    32'(rsp_tag),    32'(m_tag));
    chk("rsp_zero",   32'(rsp_zero),   32'(m_zero));
    chk("alu_opcode", 32'(alu_opcode), (q.size() == 0) ? 32'd0 : 32'(q[0].op));
    chk("alu_a",      32'(alu_a),      (q.size() == 0) ? 32'd0 : 32'(q[0].a));
    chk("alu_b",      32'(alu_b),      (q.size() == 0) ? 32'd0 : 32'(q[0].b));
  endtask

  // Entered just after a falling edge; drives one cycle's inputs, checks the
  // DUT against the model, advances the model and returns after the next falling edge.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] tag,
                       input logic rdy, input logic fl);
    cmd_t h;
    logic do_push, do_pop;
    cmd_valid  = v;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    rsp_ready  = rdy;
    flush      = fl;
    #1;
    check_state();
    do_push = v && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && (!m_rv || rdy);
    if (fl) begin
      q.delete();
      m_rv = 1'b0;
    end else begin
      if (do_pop) begin
        h      = q.pop_front();
        m_res  = alu_ref(h.op, h.a, h.b);
        m_tag  = h.tag;
        m_zero = (m_res == 8'h00);
        m_rv   = 1'b1;
      end else if (m_rv && rdy) begin
        m_rv = 1'b0;
      end
      if (do_push) q.push_back('{op, a, b, tag});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 2'd0, 8'h00, 8'h00, 4'h0, rdy, 1'b0);
  endtask

  logic [7:0] b2b_exp [4];

  initial begin
    b2b_exp = '{8'hDD, 8'h77, 8'h22, 8'hBB};
    rst_n = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0;
    cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD: response one edge after acceptance.
    cycle(1'b1, 2'd0, 8'h55, 8'h0F, 4'h3, 1'b1, 1'b0);
    chk("single_cnt", 32'(fifo_count), 32'd1);
    chk("single_v0",  32'(rsp_valid),  32'd0);
    idle(1'b1);
    chk("single_v1",  32'(rsp_valid),  32'd1);
    chk("single_res", 32'(rsp_result), 32'h64);
    chk("single_tag", 32'(rsp_tag),    32'd3);
    chk("single_z",   32'(rsp_zero),   32'd0);
    idle(1'b1);

    // Back-to-back ADD/SUB/AND/OR, no bubbles.
    for (int i = 0; i < 6; i++) begin
      cycle(i < 4, 2'(i), 8'hAA, 8'h33, 4'(i), 1'b1, 1'b0);
      if (i >= 1 && i <= 4) begin
        chk("b2b_valid", 32'(rsp_valid),  32'd1);
        chk("b2b_tag",   32'(rsp_tag),    32'(i - 1));
        chk("b2b_res",   32'(rsp_result), 32'(b2b_exp[i-1]));
      end
    end
    idle(1'b1);

    // Backpressure: six offered, five accepted.
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 2'd0, 8'(i), 8'h10, 4'(i), 1'b0, 1'b0);
    chk("bp_cnt",   32'(fifo_count), 32'd4);
    chk("bp_ready", 32'(cmd_ready),  32'd0);
    chk("bp_tag",   32'(rsp_tag),    32'd0);
    idle(1'b0);
    chk("bp_hold_tag", 32'(rsp_tag),    32'd0);
    chk("bp_hold_res", 32'(rsp_result), 32'h10);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      if (i < 4) chk("bp_drain_tag", 32'(rsp_tag), 32'(i + 1));
    end
    chk("bp_empty", 32'(fifo_count), 32'd0);

    // Zero flag and wrap.
    cycle(1'b1, 2'd2, 8'hAA, 8'h55, 4'h7, 1'b1, 1'b0);
    idle(1'b1);
    chk("zero_res", 32'(rsp_result), 32'h00);
    chk("zero_z",   32'(rsp_zero),   32'd1);
    cycle(1'b1, 2'd1, 8'h00, 8'h01, 4'h8, 1'b1, 1'b0);
    idle(1'b1);
    chk("wrap_res", 32'(rsp_result), 32'hFF);
    chk("wrap_z",   32'(rsp_zero),   32'd0);
    idle(1'b1);

    // Fill, then hold cmd_valid with rsp_ready=1: ready low that cycle, pointers wrap.
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 2'd3, 8'(i), 8'h80, 4'(i), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 2'(i), 8'(i * 7), 8'(i * 3), 4'(5 + i), 1'b1, 1'b0);
      if (i == 0) chk("full_ready_rise", 32'(cmd_ready), 32'd1);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Flush with three queued and a valid response.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 2'd0, 8'h01, 8'(i), 4'(i), 1'b0, 1'b0);
    chk("pre_flush_cnt", 32'(fifo_count), 32'd3);
    chk("pre_flush_v",   32'(rsp_valid),  32'd1);
    cycle(1'b1, 2'd0, 8'h09, 8'h09, 4'hE, 1'b0, 1'b1);
    chk("flush_cnt",   32'(fifo_count), 32'd0);
    chk("flush_v",     32'(rsp_valid),  32'd0);
    chk("flush_ready", 32'(cmd_ready),  32'd1);
    idle(1'b1);

    // Asynchronous reset mid-stream.
    cycle(1'b1, 2'd0, 8'h10, 8'h20, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 8'h11, 8'h22, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 8'h12, 8'h24, 4'h3, 1'b0, 1'b0);
    idle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid),  32'd0);
    chk("rst_cnt",   32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready),  32'd1);
    chk("rst_res",   32'(rsp_result), 32'd0);
    chk("rst_tag",   32'(rsp_tag),    32'd0);
    chk("rst_zero",  32'(rsp_zero),   32'd0);
    chk("rst_alu_a", 32'(alu_a),      32'd0);
    q.delete();
    m_rv = 1'b0; m_res = '0; m_tag = '0; m_zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 2'd3, 8'h0F, 8'hF0, 4'h9, 1'b1, 1'b0);
    idle(1'b1);
    chk("post_rst_v",   32'(rsp_valid),  32'd1);
    chk("post_rst_res", 32'(rsp_result), 32'hFF);
    chk("post_rst_tag", 32'(rsp_tag),    32'd9);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            4'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 8; i++) idle(1'b1);
    chk("final_cnt", 32'(fifo_count), 32'd0);
    chk("final_v",   32'(rsp_valid),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
